// File: rtl/execute_stage_pkg.sv
// Shared constants, ALU/alu_op/funct encodings and the EX/MEM payload for the EX stage.
package execute_stage_pkg;

  localparam int unsigned PROC_BITS = 32;
  localparam int unsigned REG_ADDR  = 5;
  localparam int unsigned SHAMT_W   = 5;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_NOR = 4'd5,
    ALU_SLT = 4'd6,
    ALU_SLL = 4'd7,
    ALU_SRL = 4'd8,
    ALU_SRA = 4'd9,
    ALU_LUI = 4'd10
  } alu_sel_e;

  typedef enum logic [2:0] {
    OP_ADD   = 3'b000,
    OP_SUB   = 3'b001,
    OP_RTYPE = 3'b010,
    OP_AND   = 3'b011,
    OP_OR    = 3'b100,
    OP_XOR   = 3'b101,
    OP_SLT   = 3'b110,
    OP_LUI   = 3'b111
  } alu_op_e;

  // ALU A-operand source: register, instruction shamt, or low bits of rs
  typedef enum logic [1:0] {
    A_RS     = 2'd0,
    A_SHAMT  = 2'd1,
    A_RS_LOW = 2'd2
  } a_sel_e;

  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_SLLV = 6'b000100;
  localparam logic [5:0] FN_SRLV = 6'b000110;
  localparam logic [5:0] FN_SRAV = 6'b000111;

  typedef struct packed {
    logic                 valid;
    logic                 reg_write;
    logic                 mem_read;
    logic                 mem_write;
    logic                 mem_to_reg;
    logic [PROC_BITS-1:0] alu_result;
    logic [PROC_BITS-1:0] store_data;
    logic [REG_ADDR-1:0]  wr_addr;
  } ex_mem_t;

  // MEM result beats WB data; register $zero is never forwarded
  function automatic logic [PROC_BITS-1:0] forward_operand(
    input logic [REG_ADDR-1:0]  src,
    input logic [PROC_BITS-1:0] reg_val,
    input logic                 mem_we,
    input logic [REG_ADDR-1:0]  mem_addr,
    input logic [PROC_BITS-1:0] mem_val,
    input logic                 wb_we,
    input logic [REG_ADDR-1:0]  wb_addr,
    input logic [PROC_BITS-1:0] wb_val
  );
    logic [PROC_BITS-1:0] val;
    val = reg_val;
    if (wb_we && (wb_addr == src) && (src != '0)) val = wb_val;
    if (mem_we && (mem_addr == src) && (src != '0)) val = mem_val;
    return val;
  endfunction

endpackage

// File: rtl/execute_stage_alu.sv
// Combinational ALU; shifts move B by A[4:0], LUI moves B up by 16.
module execute_stage_alu
  import execute_stage_pkg::*;
(
  input  logic [PROC_BITS-1:0] a,
  input  logic [PROC_BITS-1:0] b,
  input  logic [3:0]           operation,
  output logic [PROC_BITS-1:0] result_c
);

  logic [SHAMT_W-1:0] amt;

  assign amt = a[SHAMT_W-1:0];

  always_comb begin
    result_c = '0;
    case (operation)
      ALU_ADD: result_c = a + b;
      ALU_SUB: result_c = a - b;
      ALU_AND: result_c = a & b;
      ALU_OR:  result_c = a | b;
      ALU_XOR: result_c = a ^ b;
      ALU_NOR: result_c = ~(a | b);
      ALU_SLT: result_c = PROC_BITS'($signed(a) < $signed(b));
      ALU_SLL: result_c = b << amt;
      ALU_SRL: result_c = b >> amt;
      ALU_SRA: result_c = PROC_BITS'($signed(b) >>> amt);
      ALU_LUI: result_c = b << 16;
      default: result_c = '0;
    endcase
  end

endmodule

// File: rtl/execute_stage_alu_control.sv
// Decodes alu_op/funct into the ALU operation, A-operand source and an illegal-funct flag.
module execute_stage_alu_control
  import execute_stage_pkg::*;
(
  input  logic [2:0] alu_op,
  input  logic [5:0] funct,
  output logic [3:0] operation_c,
  output logic [1:0] a_sel_c,
  output logic       illegal_c
);

  always_comb begin
    operation_c = ALU_ADD;
    a_sel_c     = A_RS;
    illegal_c   = 1'b0;
    case (alu_op)
      OP_ADD: operation_c = ALU_ADD;
      OP_SUB: operation_c = ALU_SUB;
      OP_AND: operation_c = ALU_AND;
      OP_OR:  operation_c = ALU_OR;
      OP_XOR: operation_c = ALU_XOR;
      OP_SLT: operation_c = ALU_SLT;
      OP_LUI: operation_c = ALU_LUI;
      OP_RTYPE: begin
        case (funct)
          FN_ADD, FN_ADDU: operation_c = ALU_ADD;
          FN_SUB, FN_SUBU: operation_c = ALU_SUB;
          FN_AND:          operation_c = ALU_AND;
          FN_OR:           operation_c = ALU_OR;
          FN_XOR:          operation_c = ALU_XOR;
          FN_NOR:          operation_c = ALU_NOR;
          FN_SLT:          operation_c = ALU_SLT;
          FN_SLL:  begin operation_c = ALU_SLL; a_sel_c = A_SHAMT;  end
          FN_SRL:  begin operation_c = ALU_SRL; a_sel_c = A_SHAMT;  end
          FN_SRA:  begin operation_c = ALU_SRA; a_sel_c = A_SHAMT;  end
          FN_SLLV: begin operation_c = ALU_SLL; a_sel_c = A_RS_LOW; end
          FN_SRLV: begin operation_c = ALU_SRL; a_sel_c = A_RS_LOW; end
          FN_SRAV: begin operation_c = ALU_SRA; a_sel_c = A_RS_LOW; end
          default: illegal_c = 1'b1;
        endcase
      end
      default: illegal_c = 1'b1;
    endcase
  end

endmodule

// File: rtl/execute_stage.sv
// EX stage: operand forwarding, ALU control/ALU, EX/MEM pipeline register.
// Optional macro EX_FORWARDING_EN enables MEM/WB forwarding onto rs/rt.
module execute_stage
  import execute_stage_pkg::*;
(
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_stall,
  input  logic                 i_flush,
  input  logic                 i_valid,
  input  logic [PROC_BITS-1:0] i_rs_data,
  input  logic [PROC_BITS-1:0] i_rt_data,
  input  logic [PROC_BITS-1:0] i_imm_ext,
  input  logic [4:0]           i_shamt,
  input  logic [5:0]           i_funct,
  input  logic [2:0]           i_alu_op,
  input  logic                 i_alu_src,
  input  logic                 i_reg_dst,
  input  logic [REG_ADDR-1:0]  i_rs_addr,
  input  logic [REG_ADDR-1:0]  i_rt_addr,
  input  logic [REG_ADDR-1:0]  i_rd_addr,
  input  logic                 i_reg_write,
  input  logic                 i_mem_read,
  input  logic                 i_mem_write,
  input  logic                 i_mem_to_reg,
  input  logic                 i_mem_reg_write,
  input  logic [REG_ADDR-1:0]  i_mem_wr_addr,
  input  logic [PROC_BITS-1:0] i_mem_result,
  input  logic                 i_wb_reg_write,
  input  logic [REG_ADDR-1:0]  i_wb_wr_addr,
  input  logic [PROC_BITS-1:0] i_wb_data,
  output logic                 o_valid,
  output logic                 o_reg_write,
  output logic                 o_mem_read,
  output logic                 o_mem_write,
  output logic                 o_mem_to_reg,
  output logic [PROC_BITS-1:0] o_alu_result,
  output logic [PROC_BITS-1:0] o_store_data,
  output logic [REG_ADDR-1:0]  o_wr_addr
);

  logic [PROC_BITS-1:0] rs_fwd;
  logic [PROC_BITS-1:0] rt_fwd;
  logic [PROC_BITS-1:0] alu_a;
  logic [PROC_BITS-1:0] alu_b;
  logic [PROC_BITS-1:0] alu_result_c;
  logic [3:0]           operation_c;
  logic [1:0]           a_sel_c;
  logic                 illegal_c;
  ex_mem_t              ex_mem_d;
  ex_mem_t              ex_mem_q;

`ifdef EX_FORWARDING_EN
  assign rs_fwd = forward_operand(i_rs_addr, i_rs_data, i_mem_reg_write, i_mem_wr_addr,
                                  i_mem_result, i_wb_reg_write, i_wb_wr_addr, i_wb_data);
  assign rt_fwd = forward_operand(i_rt_addr, i_rt_data, i_mem_reg_write, i_mem_wr_addr,
                                  i_mem_result, i_wb_reg_write, i_wb_wr_addr, i_wb_data);
`else
  logic unused_fwd;

  assign rs_fwd     = i_rs_data;
  assign rt_fwd     = i_rt_data;
  assign unused_fwd = ^{i_rs_addr, i_mem_reg_write, i_mem_wr_addr, i_mem_result,
                        i_wb_reg_write, i_wb_wr_addr, i_wb_data};
`endif

  execute_stage_alu_control u_alu_control (
    .alu_op      (i_alu_op),
    .funct       (i_funct),
    .operation_c (operation_c),
    .a_sel_c     (a_sel_c),
    .illegal_c   (illegal_c)
  );

  // Operand selection; LUI always takes the immediate on B
  always_comb begin
    alu_a = rs_fwd;
    if (a_sel_c == A_SHAMT)  alu_a = PROC_BITS'(i_shamt);
    if (a_sel_c == A_RS_LOW) alu_a = PROC_BITS'(rs_fwd[SHAMT_W-1:0]);
    alu_b = (i_alu_src || (i_alu_op == OP_LUI)) ? i_imm_ext : rt_fwd;
  end

  execute_stage_alu u_alu (
    .a         (alu_a),
    .b         (alu_b),
    .operation (operation_c),
    .result_c  (alu_result_c)
  );

  // Next EX/MEM payload; an invalid slot becomes an all-zero bubble
  always_comb begin
    ex_mem_d = '0;
    if (i_valid) begin
      ex_mem_d.valid      = 1'b1;
      ex_mem_d.reg_write  = i_reg_write && !illegal_c;
      ex_mem_d.mem_read   = i_mem_read;
      ex_mem_d.mem_write  = i_mem_write;
      ex_mem_d.mem_to_reg = i_mem_to_reg;
      ex_mem_d.alu_result = illegal_c ? '0 : alu_result_c;
      ex_mem_d.store_data = rt_fwd;
      ex_mem_d.wr_addr    = i_reg_dst ? i_rd_addr : i_rt_addr;
    end
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      ex_mem_q <= '0;
    end else if (i_flush) begin
      ex_mem_q <= '0;
    end else if (!i_stall) begin
      ex_mem_q <= ex_mem_d;
    end
  end

  assign o_valid      = ex_mem_q.valid;
  assign o_reg_write  = ex_mem_q.reg_write;
  assign o_mem_read   = ex_mem_q.mem_read;
  assign o_mem_write  = ex_mem_q.mem_write;
  assign o_mem_to_reg = ex_mem_q.mem_to_reg;
  assign o_alu_result = ex_mem_q.alu_result;
  assign o_store_data = ex_mem_q.store_data;
  assign o_wr_addr    = ex_mem_q.wr_addr;

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: directed vector table, hand sequences, random vs model.
module tb_execute_stage;

  typedef struct packed {
    logic        valid;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [2:0]  alu_op;
    logic        alu_src;
    logic        reg_dst;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [4:0]  rd_addr;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic        mem_rw;
    logic [4:0]  mem_addr;
    logic [31:0] mem_result;
    logic        wb_rw;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
  } in_t;

  typedef struct packed {
    logic        valid;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic [31:0] result;
    logic [31:0] store;
    logic [4:0]  wr_addr;
  } out_t;

  typedef struct packed {
    in_t         in;
    logic [31:0] exp_result;
    logic [4:0]  exp_wr;
    logic        exp_rw;
    logic        exp_valid;
  } vec_t;

  logic        clk;
  logic        reset_n;
  logic        stall;
  logic        flush;
  in_t         cur;
  out_t        exp_q;
  out_t        got;
  logic        o_valid, o_reg_write, o_mem_read, o_mem_write, o_mem_to_reg;
  logic [31:0] o_alu_result, o_store_data;
  logic [4:0]  o_wr_addr;
  int          n_checks;
  int          n_pass;

  execute_stage dut (
    .i_clock         (clk),
    .i_reset         (reset_n),
    .i_stall         (stall),
    .i_flush         (flush),
    .i_valid         (cur.valid),
    .i_rs_data       (cur.rs_data),
    .i_rt_data       (cur.rt_data),
    .i_imm_ext       (cur.imm),
    .i_shamt         (cur.shamt),
    .i_funct         (cur.funct),
    .i_alu_op        (cur.alu_op),
    .i_alu_src       (cur.alu_src),
    .i_reg_dst       (cur.reg_dst),
    .i_rs_addr       (cur.rs_addr),
    .i_rt_addr       (cur.rt_addr),
    .i_rd_addr       (cur.rd_addr),
    .i_reg_write     (cur.reg_write),
    .i_mem_read      (cur.mem_read),
    .i_mem_write     (cur.mem_write),
    .i_mem_to_reg    (cur.mem_to_reg),
    .i_mem_reg_write (cur.mem_rw),
    .i_mem_wr_addr   (cur.mem_addr),
    .i_mem_result    (cur.mem_result),
    .i_wb_reg_write  (cur.wb_rw),
    .i_wb_wr_addr    (cur.wb_addr),
    .i_wb_data       (cur.wb_data),
    .o_valid         (o_valid),
    .o_reg_write     (o_reg_write),
    .o_mem_read      (o_mem_read),
    .o_mem_write     (o_mem_write),
    .o_mem_to_reg    (o_mem_to_reg),
    .o_alu_result    (o_alu_result),
    .o_store_data    (o_store_data),
    .o_wr_addr       (o_wr_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign got = '{o_valid, o_reg_write, o_mem_read, o_mem_write, o_mem_to_reg,
                 o_alu_result, o_store_data, o_wr_addr};

  // Reference: register value unless a writing later stage targets the same nonzero register
  function automatic logic [31:0] fwd(logic [4:0] addr, logic [31:0] val, in_t x);
`ifdef EX_FORWARDING_EN
    if (addr != 5'd0 && x.mem_rw && x.mem_addr == addr) return x.mem_result;
    if (addr != 5'd0 && x.wb_rw && x.wb_addr == addr) return x.wb_data;
`endif
    return val;
  endfunction

  function automatic out_t model(in_t x);
    out_t        o;
    logic [31:0] a, rt, b, r;
    logic        ok;
    o = '0;
    if (!x.valid) return o;
    a  = fwd(x.rs_addr, x.rs_data, x);
    rt = fwd(x.rt_addr, x.rt_data, x);
    b  = x.alu_src ? x.imm : rt;
    ok = 1'b1;
    r  = 32'd0;
    case (x.alu_op)
      3'd0: r = a + b;
      3'd1: r = a - b;
      3'd3: r = a & b;
      3'd4: r = a | b;
      3'd5: r = a ^ b;
      3'd6: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd7: r = {x.imm[15:0], 16'h0000};
      default: begin
        case (x.funct)
          6'h20, 6'h21: r = a + b;
          6'h22, 6'h23: r = a - b;
          6'h24: r = a & b;
          6'h25: r = a | b;
          6'h26: r = a ^ b;
          6'h27: r = ~(a | b);
          6'h2a: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          6'h00: r = b << x.shamt;
          6'h02: r = b >> x.shamt;
          6'h03: r = 32'($signed(b) >>> x.shamt);
          6'h04: r = b << a[4:0];
          6'h06: r = b >> a[4:0];
          6'h07: r = 32'($signed(b) >>> a[4:0]);
          default: ok = 1'b0;
        endcase
      end
    endcase
    o.valid      = 1'b1;
    o.reg_write  = x.reg_write & ok;
    o.mem_read   = x.mem_read;
    o.mem_write  = x.mem_write;
    o.mem_to_reg = x.mem_to_reg;
    o.result     = ok ? r : 32'd0;
    o.store      = rt;
    o.wr_addr    = x.reg_dst ? x.rd_addr : x.rt_addr;
    return o;
  endfunction

  task automatic chk(input string name, input logic [79:0] actual, input logic [79:0] required);
    n_checks++;
    if (actual === required) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, actual, required);
  endtask

  // One clock: drive, update the expected register image, sample 1ns after the edge
  task automatic step(input in_t x, input logic rst, input logic stl, input logic fl);
    cur     = x;
    reset_n = rst;
    stall   = stl;
    flush   = fl;
    @(posedge clk);
    if (!rst || fl) exp_q = '0;
    else if (!stl) exp_q = model(x);
    #1;
    chk("pipe", 80'(got), 80'(exp_q));
  endtask

  function automatic in_t base();
    in_t x;
    x = '0;
    x.valid     = 1'b1;
    x.reg_write = 1'b1;
    return x;
  endfunction

  function automatic logic [5:0] pick_funct(int k);
    case (k)
      0: return 6'h20;  1: return 6'h21;  2: return 6'h22;  3: return 6'h23;
      4: return 6'h24;  5: return 6'h25;  6: return 6'h26;  7: return 6'h27;
      8: return 6'h2a;  9: return 6'h00; 10: return 6'h02; 11: return 6'h03;
      12: return 6'h04; 13: return 6'h06; 14: return 6'h07;
      default: return 6'($urandom_range(0, 63));
    endcase
  endfunction

  function automatic in_t rand_in();
    in_t x;
    x            = '0;
    x.valid      = ($urandom_range(0, 9) != 0);
    x.rs_data    = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
    x.rt_data    = $urandom;
    x.imm        = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 16'hffff)) : $urandom;
    x.shamt      = 5'($urandom_range(0, 31));
    x.funct      = pick_funct($urandom_range(0, 16));
    x.alu_op     = 3'($urandom_range(0, 7));
    x.alu_src    = (x.alu_op == 3'd2) ? 1'b0 : 1'($urandom_range(0, 1));
    x.reg_dst    = 1'($urandom_range(0, 1));
    x.rs_addr    = 5'($urandom_range(0, 3));
    x.rt_addr    = 5'($urandom_range(0, 3));
    x.rd_addr    = 5'($urandom_range(0, 31));
    x.reg_write  = 1'($urandom_range(0, 1));
    x.mem_read   = 1'($urandom_range(0, 1));
    x.mem_write  = 1'($urandom_range(0, 1));
    x.mem_to_reg = 1'($urandom_range(0, 1));
    x.mem_rw     = 1'($urandom_range(0, 1));
    x.mem_addr   = 5'($urandom_range(0, 3));
    x.mem_result = $urandom;
    x.wb_rw      = 1'($urandom_range(0, 1));
    x.wb_addr    = 5'($urandom_range(0, 3));
    x.wb_data    = $urandom;
    return x;
  endfunction

  vec_t vecs[15];

  initial begin
    in_t  x;
    in_t  add_in;
    vec_t v;
    n_checks = 0;
    n_pass   = 0;
    exp_q    = '0;
    cur      = base();
    reset_n  = 1'b0;
    stall    = 1'b0;
    flush    = 1'b0;

    // Directed table: {inputs, result, wr_addr, reg_write, valid}
    x = base(); x.rs_data = 5; x.rt_data = 7; x.alu_op = 3'd2; x.funct = 6'h20; x.rd_addr = 3; x.reg_dst = 1;
    add_in = x;
    vecs[0] = '{x, 32'd12, 5'd3, 1'b1, 1'b1};
    x = base(); x.rs_addr = 4; x.rs_data = 20; x.mem_rw = 1; x.mem_addr = 4; x.mem_result = 100;
    x.wb_rw = 1; x.wb_addr = 4; x.wb_data = 9; x.imm = 1; x.alu_src = 1; x.rt_addr = 8;
`ifdef EX_FORWARDING_EN
    vecs[1] = '{x, 32'd101, 5'd8, 1'b1, 1'b1};
`else
    vecs[1] = '{x, 32'd21, 5'd8, 1'b1, 1'b1};
`endif
    x = base(); x.rs_addr = 6; x.rs_data = 20; x.wb_rw = 1; x.wb_addr = 6; x.wb_data = 9;
    x.mem_rw = 1; x.mem_addr = 7; x.mem_result = 100; x.imm = 1; x.alu_src = 1; x.rt_addr = 2;
`ifdef EX_FORWARDING_EN
    vecs[2] = '{x, 32'd10, 5'd2, 1'b1, 1'b1};
`else
    vecs[2] = '{x, 32'd21, 5'd2, 1'b1, 1'b1};
`endif
    x = base(); x.mem_rw = 1; x.mem_result = 55; x.imm = 3; x.alu_src = 1; x.rt_addr = 9;
    vecs[3] = '{x, 32'd3, 5'd9, 1'b1, 1'b1};
    x = base(); x.rt_data = 32'h8000_0000; x.shamt = 4; x.alu_op = 3'd2; x.funct = 6'h03; x.rd_addr = 5; x.reg_dst = 1;
    vecs[4] = '{x, 32'hF800_0000, 5'd5, 1'b1, 1'b1};
    x = base(); x.rs_data = 36; x.rt_data = 32'h100; x.alu_op = 3'd2; x.funct = 6'h06; x.rd_addr = 6; x.reg_dst = 1;
    vecs[5] = '{x, 32'h10, 5'd6, 1'b1, 1'b1};
    x = base(); x.alu_op = 3'd7; x.imm = 32'h1234; x.alu_src = 1; x.rt_addr = 10;
    vecs[6] = '{x, 32'h1234_0000, 5'd10, 1'b1, 1'b1};
    x = base(); x.alu_op = 3'd1; x.rs_data = 0; x.rt_data = 1; x.rt_addr = 11;
    vecs[7] = '{x, 32'hFFFF_FFFF, 5'd11, 1'b1, 1'b1};
    x = base(); x.alu_op = 3'd2; x.funct = 6'h2a; x.rs_data = 32'hFFFF_FFFF; x.rt_data = 1; x.rd_addr = 12; x.reg_dst = 1;
    vecs[8] = '{x, 32'd1, 5'd12, 1'b1, 1'b1};
    x = base(); x.alu_op = 3'd2; x.funct = 6'h27; x.rs_data = 32'hF0F0_F0F0; x.rt_data = 32'h0F0F_0000; x.rd_addr = 13; x.reg_dst = 1;
    vecs[9] = '{x, 32'h0000_0F0F, 5'd13, 1'b1, 1'b1};
    x = base(); x.alu_op = 3'd2; x.funct = 6'h3f; x.rs_data = 5; x.rt_data = 7; x.rd_addr = 14; x.reg_dst = 1;
    vecs[10] = '{x, 32'd0, 5'd14, 1'b0, 1'b1};
    x = base(); x.alu_op = 3'd2; x.funct = 6'h00; x.rt_data = 1; x.shamt = 31; x.rd_addr = 15; x.reg_dst = 1;
    vecs[11] = '{x, 32'h8000_0000, 5'd15, 1'b1, 1'b1};
    x = base(); x.rs_data = 32'hFFFF_FFFF; x.imm = 2; x.alu_src = 1; x.rt_addr = 16;
    vecs[12] = '{x, 32'd1, 5'd16, 1'b1, 1'b1};
    x = add_in; x.valid = 0;
    vecs[13] = '{x, 32'd0, 5'd0, 1'b0, 1'b0};
    x = base(); x.alu_op = 3'd2; x.funct = 6'h07; x.rs_data = 32'h21; x.rt_data = 32'h8000_0000; x.rd_addr = 17; x.reg_dst = 1;
    vecs[14] = '{x, 32'hC000_0000, 5'd17, 1'b1, 1'b1};

    // Reset state
    step(base(), 1'b0, 1'b0, 1'b0);
    chk("reset_zero", 80'(got), 80'd0);
    step(base(), 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 15; i++) begin
      v = vecs[i];
      step(v.in, 1'b1, 1'b0, 1'b0);
      chk($sformatf("vec%0d_result", i), 80'(o_alu_result), 80'(v.exp_result));
      chk($sformatf("vec%0d_wr_addr", i), 80'(o_wr_addr), 80'(v.exp_wr));
      chk($sformatf("vec%0d_reg_write", i), 80'(o_reg_write), 80'(v.exp_rw));
      chk($sformatf("vec%0d_valid", i), 80'(o_valid), 80'(v.exp_valid));
    end

    // Stall holds for three cycles while inputs change
    step(add_in, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(rand_in(), 1'b1, 1'b1, 1'b0);
      chk("stall_hold_result", 80'(o_alu_result), 80'd12);
      chk("stall_hold_wr", 80'(o_wr_addr), 80'd3);
    end
    // Flush wins over stall
    step(add_in, 1'b1, 1'b1, 1'b1);
    chk("flush_stall_bubble", 80'(got), 80'd0);

    // Reset mid-stream clears a live write
    step(add_in, 1'b1, 1'b0, 1'b0);
    chk("pre_reset_rw", 80'(o_reg_write), 80'd1);
    step(add_in, 1'b0, 1'b0, 1'b0);
    chk("mid_reset_zero", 80'(got), 80'd0);

    // Random stream with occasional stall/flush/reset
    for (int i = 0; i < 600; i++) begin
      step(rand_in(), ($urandom_range(0, 31) != 0), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 15) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
